// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller feeding a 16-bit ALU: accepts 3-operand register
// instructions, reads an 8x16 register file, drives the ALU, and writes the result back.
module alu_exec_ctrl #(
    parameter int ALU_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    input  logic        ext_we,
    input  logic [2:0]  ext_addr,
    input  logic [15:0] ext_wdata,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_opcode,
    input  logic [15:0] alu_result,
    input  logic        alu_zero,
    output logic        done,
    output logic        zero_flag,
    output logic        err
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    localparam logic [2:0] OP_DIV     = 3'b011;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    logic [1:0]  state_reg;
    logic [15:0] regs_reg [8];
    logic [2:0]  rd_reg;
    logic [2:0]  op_reg;
    logic [3:0]  cnt_reg;
    logic [15:0] res_reg;
    logic        zcap_reg;
    logic        accept;
    logic        fault;

    // External writes take priority over instruction acceptance in IDLE.
    assign instr_ready = (state_reg == ST_IDLE) && !ext_we;
    assign accept      = instr_valid && instr_ready;
    assign dbg_data    = regs_reg[dbg_addr];
    assign fault       = (op_reg == OP_ILLEGAL) || ((op_reg == OP_DIV) && (alu_b == 16'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs_reg[i] <= 16'd0;
            end
        end else if ((state_reg == ST_IDLE) && ext_we) begin
            regs_reg[ext_addr] <= ext_wdata;
        end else if ((state_reg == ST_WB) && !fault) begin
            regs_reg[rd_reg] <= res_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            alu_a      <= 16'd0;
            alu_b      <= 16'd0;
            alu_opcode <= 3'd0;
            rd_reg     <= 3'd0;
            op_reg     <= 3'd0;
            cnt_reg    <= 4'd0;
            res_reg    <= 16'd0;
            zcap_reg   <= 1'b0;
            zero_flag  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        alu_a      <= regs_reg[instr[9:7]];
                        alu_b      <= regs_reg[instr[6:4]];
                        alu_opcode <= instr[15:13];
                        op_reg     <= instr[15:13];
                        rd_reg     <= instr[12:10];
                        cnt_reg    <= 4'(ALU_LATENCY - 1);
                        state_reg  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Counter runs down so the capture edge is E0+ALU_LATENCY.
                    if (cnt_reg == 4'd0) begin
                        res_reg   <= alu_result;
                        zcap_reg  <= alu_zero;
                        state_reg <= ST_WB;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ST_WB: begin
                    if (fault) begin
                        err <= 1'b1;
                    end else begin
                        zero_flag <= zcap_reg;
                    end
                    done      <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: table-driven instructions with a scoreboard,
// plus hand-written sequences for write/accept priority, streaming and mid-flight reset.
module tb_alu_exec_ctrl;
    localparam int L = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        ext_we;
    logic [2:0]  ext_addr;
    logic [15:0] ext_wdata;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_opcode;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic        done;
    logic        zero_flag;
    logic        err;

    alu_exec_ctrl #(.ALU_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .alu_a(alu_a), .alu_b(alu_b),
        .alu_opcode(alu_opcode), .alu_result(alu_result), .alu_zero(alu_zero),
        .done(done), .zero_flag(zero_flag), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the external ALU.
    always_comb begin
        case (alu_opcode)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a * alu_b;
            3'b011:  alu_result = (alu_b == 16'd0) ? 16'd0 : alu_a / alu_b;
            3'b100:  alu_result = alu_a | alu_b;
            3'b101:  alu_result = ~(alu_a | alu_b);
            3'b110:  alu_result = ~(alu_a & alu_b);
            default: alu_result = 16'd0;
        endcase
        alu_zero = (alu_result == 16'd0);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] val;
        logic        z;
        logic        e;
    } exp_t;

    typedef struct {
        logic [15:0] ins;
        logic [15:0] val;
        logic        z;
        logic        e;
    } vec_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   last_acc = 0;

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 4'b0000};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        ext_we = 1'b1; ext_addr = a; ext_wdata = d;
        @(negedge clk);
        ext_we = 1'b0;
    endtask

    // Offer an instruction until accepted; records the accept cycle and queues its expectation.
    task automatic issue(input logic [15:0] ins, input logic [15:0] val, input logic z, input logic e);
        int k;
        exp_t x;
        x.rd = ins[12:10]; x.val = val; x.z = z; x.e = e;
        sb.push_back(x);
        instr = ins; instr_valid = 1'b1;
        #1;
        k = 0;
        while (!instr_ready && k < 50) begin
            @(negedge clk); #1; k++;
        end
        if (k == 50) chk("accept_timeout", 32'd1, 32'd0);
        @(negedge clk);
        last_acc = cyc;
        instr_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        exp_t x;
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            if (done) break;
            k++;
        end
        if (k == 100) begin
            chk("done_timeout", 32'd1, 32'd0);
        end else begin
            chk("done_latency", cyc - last_acc, L + 1);
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                x = sb.pop_front();
                chk("err", {31'd0, err}, {31'd0, x.e});
                chk("zero_flag", {31'd0, zero_flag}, {31'd0, x.z});
                dbg_addr = x.rd;
                #1;
                chk("rd_value", {16'd0, dbg_data}, {16'd0, x.val});
            end
        end
    endtask

    vec_t tbl[10];
    int   acc_prev;
    logic saw_done;

    initial begin
        tbl[0] = '{enc(3'b000, 3, 1, 2), 16'd47,   1'b0, 1'b0};
        tbl[1] = '{enc(3'b001, 6, 4, 5), 16'd0,    1'b1, 1'b0};
        tbl[2] = '{enc(3'b010, 6, 4, 5), 16'd100,  1'b0, 1'b0};
        tbl[3] = '{enc(3'b101, 0, 4, 5), 16'hFFF5, 1'b0, 1'b0};
        tbl[4] = '{enc(3'b110, 3, 1, 2), 16'hFFFF, 1'b0, 1'b0};
        tbl[5] = '{enc(3'b100, 6, 1, 2), 16'd47,   1'b0, 1'b0};
        tbl[6] = '{enc(3'b001, 6, 4, 5), 16'd0,    1'b1, 1'b0};
        tbl[7] = '{enc(3'b011, 7, 4, 6), 16'd99,   1'b1, 1'b1};
        tbl[8] = '{enc(3'b111, 7, 4, 5), 16'd99,   1'b1, 1'b1};
        tbl[9] = '{enc(3'b011, 7, 5, 4), 16'd1,    1'b0, 1'b0};

        rst_n = 1'b0; instr_valid = 1'b0; instr = 16'd0;
        ext_we = 1'b0; ext_addr = 3'd0; ext_wdata = 16'd0; dbg_addr = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
        chk("rst_alu_b", {16'd0, alu_b}, 32'd0);
        chk("rst_opcode", {29'd0, alu_opcode}, 32'd0);
        chk("rst_flags", {29'd0, done, err, zero_flag}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        preload(3'd1, 16'd12);
        preload(3'd2, 16'd35);
        preload(3'd4, 16'd10);
        preload(3'd5, 16'd10);
        preload(3'd7, 16'd99);

        for (int i = 0; i < 10; i++) begin
            issue(tbl[i].ins, tbl[i].val, tbl[i].z, tbl[i].e);
            if (i == 0) begin
                chk("add_alu_a", {16'd0, alu_a}, 32'd12);
                chk("add_alu_b", {16'd0, alu_b}, 32'd35);
                chk("add_opcode", {29'd0, alu_opcode}, 32'd0);
            end
            wait_done();
        end

        // Divide by zero and illegal op: error pulse, R7 and zero_flag preserved.
        preload(3'd1, 16'd80);
        preload(3'd2, 16'd0);
        issue(enc(3'b011, 7, 1, 2), 16'd1, 1'b0, 1'b1);
        chk("div_alu_b", {16'd0, alu_b}, 32'd0);
        wait_done();
        issue(enc(3'b111, 7, 1, 2), 16'd1, 1'b0, 1'b1);
        wait_done();

        // External write beats a same-cycle instruction.
        ext_we = 1'b1; ext_addr = 3'd0; ext_wdata = 16'd5;
        instr = enc(3'b000, 3, 0, 0); instr_valid = 1'b1;
        #1;
        chk("ready_blocked", {31'd0, instr_ready}, 32'd0);
        @(negedge clk);
        ext_we = 1'b0; dbg_addr = 3'd0;
        #1;
        chk("r0_written", {16'd0, dbg_data}, 32'd5);
        chk("ready_after_we", {31'd0, instr_ready}, 32'd1);
        issue(enc(3'b000, 3, 0, 0), 16'd10, 1'b0, 1'b0);
        wait_done();

        // Back-to-back stream, accept spacing ALU_LATENCY+2.
        preload(3'd1, 16'd3);
        acc_prev = 0;
        for (int i = 0; i < 3; i++) begin
            issue(enc(3'b000, 1, 1, 1), 16'(6 << i), 1'b0, 1'b0);
            if (i > 0) chk("accept_spacing", last_acc - acc_prev, L + 2);
            acc_prev = last_acc;
            wait_done();
        end

        // Reset mid-EXEC drops the instruction.
        instr = enc(3'b100, 2, 1, 1); instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_alu_a", {16'd0, alu_a}, 32'd0);
        chk("mid_rst_alu_b", {16'd0, alu_b}, 32'd0);
        chk("mid_rst_flags", {29'd0, done, err, zero_flag}, 32'd0);
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r);
            #1;
            chk($sformatf("mid_rst_r%0d", r), {16'd0, dbg_data}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (2 * L + 4) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("no_done_after_rst", {31'd0, saw_done}, 32'd0);
        dbg_addr = 3'd2;
        #1;
        chk("r2_not_written", {16'd0, dbg_data}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
